regfile_context_unit: RTL

Context save/restore engine acting as the access initiator for the 8x8 register file. On a save command it reads R1..R7 through the register file's A read port and streams the bytes out over a valid/ready interface; on a restore command it accepts bytes over a valid/ready interface and writes them into R1..R7 through the register file's write port. It sits between the register file and an external context store (stack RAM or debug link). It serves interrupt entry/exit and debug state dump.

---
 rtl/regfile_context_unit.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/regfile_context_unit.sv
// regfile_context_unit: context save/restore engine for the 8x8 register file.
// A save reads FIRST_REG..LAST_REG through read port A and streams the bytes
// out on a valid/ready link. A restore accepts bytes from a valid/ready link
// and writes them into FIRST_REG..LAST_REG through the write port. R0 is
// never addressed, so it is never written.
module regfile_context_unit #(
    parameter int unsigned FIRST_REG = 1,
    parameter int unsigned LAST_REG  = 7
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       save_i,
    input  logic       restore_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [2:0] aa_o,
    input  logic [7:0] data_a_i,
    output logic [2:0] da_o,
    output logic [7:0] wr_data_o,
    output logic       wr_o,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic       rx_ready_o
);

    localparam logic [2:0] FIRST_IDX = 3'(FIRST_REG);
    localparam logic [2:0] LAST_IDX  = 3'(LAST_REG);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SAVE_LOAD = 3'd1,
        S_SAVE_SEND = 3'd2,
        S_RST_WAIT  = 3'd3,
        S_RST_WRITE = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] aa_q, aa_d;
    logic [2:0] da_q, da_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       wr_q, wr_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_valid_q, tx_valid_d;
    logic       rx_ready_q, rx_ready_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    // Next-state and next-output logic; every register holds unless changed.
    always_comb begin
        state_d    = state_q;
        aa_d       = aa_q;
        da_d       = da_q;
        wr_data_d  = wr_data_q;
        wr_d       = wr_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        rx_ready_d = rx_ready_q;

        case (state_q)
            S_IDLE: begin
                // Save wins over restore when both arrive together.
                if (save_i) begin
                    aa_d    = FIRST_IDX;
                    state_d = S_SAVE_LOAD;
                end else if (restore_i) begin
                    da_d       = FIRST_IDX;
                    rx_ready_d = 1'b1;
                    state_d    = S_RST_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SAVE_LOAD: begin
                tx_data_d  = data_a_i;
                tx_valid_d = 1'b1;
                state_d    = S_SAVE_SEND;
            end
            S_SAVE_SEND: begin
                // Byte and valid are held until the sink takes them.
                if (tx_valid_q && tx_ready_i) begin
                    tx_valid_d = 1'b0;
                    if (aa_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        aa_d    = aa_q + 3'd1;
                        state_d = S_SAVE_LOAD;
                    end
                end else begin
                    state_d = S_SAVE_SEND;
                end
            end
            S_RST_WAIT: begin
                if (rx_valid_i && rx_ready_q) begin
                    wr_data_d  = rx_data_i;
                    wr_d       = 1'b1;
                    rx_ready_d = 1'b0;
                    state_d    = S_RST_WRITE;
                end else begin
                    state_d = S_RST_WAIT;
                end
            end
            S_RST_WRITE: begin
                // The write strobe lasts exactly one cycle per byte.
                wr_d = 1'b0;
                if (da_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    da_d       = da_q + 3'd1;
                    rx_ready_d = 1'b1;
                    state_d    = S_RST_WAIT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d    = S_IDLE;
                wr_d       = 1'b0;
                tx_valid_d = 1'b0;
                rx_ready_d = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            aa_q       <= 3'd0;
            da_q       <= 3'd0;
            wr_data_q  <= 8'd0;
            wr_q       <= 1'b0;
            tx_data_q  <= 8'd0;
            tx_valid_q <= 1'b0;
            rx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            aa_q       <= aa_d;
            da_q       <= da_d;
            wr_data_q  <= wr_data_d;
            wr_q       <= wr_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            rx_ready_q <= rx_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign aa_o       = aa_q;
    assign da_o       = da_q;
    assign wr_data_o  = wr_data_q;
    assign wr_o       = wr_q;
    assign tx_data_o  = tx_data_q;
    assign tx_valid_o = tx_valid_q;
    assign rx_ready_o = rx_ready_q;

endmodule
